mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-master round-robin arbiter in front of the startup RAM
// controller. Master 0 is the CPU core and master 1 is the loader/DMA. One
// request is granted at a time, held on the RAM side until the matching done
// pulse, then answered with a one-cycle done (plus read data) to that master.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a request that the RAM
// leaves unanswered for TIMEOUT_CYCLES cycles (err + rw_halt pulses).
module mem_req_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (CPU core)
    input  logic              m0_read_q,
    input  logic              m0_write_q,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_read_dn,
    output logic              m0_write_dn,
    output logic              m0_err,
    // master 1 (loader/DMA)
    input  logic              m1_read_q,
    input  logic              m1_write_q,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_read_dn,
    output logic              m1_write_dn,
    output logic              m1_err,
    // RAM side
    output logic              read_q,
    output logic              write_q,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_dn,
    input  logic              write_dn,
    output logic              rw_halt
);

    // The watchdog counter would be zero bits wide below this limit.
    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("mem_req_arbiter: TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg;
    logic              last_grant_reg;
    logic              grant_reg;
    logic              read_q_reg;
    logic              write_q_reg;
    logic [ADDR_W-1:0] addr_out_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [1:0]        read_dn_reg;
    logic [1:0]        write_dn_reg;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        err_reg;
    logic              rw_halt_reg;
`endif

    // Per-master request view, indexed by master number.
    logic [1:0]        req_rd;
    logic [1:0]        req_wr;
    logic [1:0]        pend;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic              pick;

    assign req_rd       = {m1_read_q,  m0_read_q};
    assign req_wr       = {m1_write_q, m0_write_q};
    assign req_addr[0]  = m0_addr;
    assign req_addr[1]  = m1_addr;
    assign req_wdata[0] = m0_wdata;
    assign req_wdata[1] = m1_wdata;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pend
            assign pend[gi] = req_rd[gi] | req_wr[gi];
        end
    endgenerate

    // Round-robin pick: on contention the master not served last wins.
    always_comb begin
        pick = 1'b0;
        if (pend == 2'b11) begin
            pick = ~last_grant_reg;
        end else begin
            pick = pend[1];
        end
    end

    // Arbitration FSM with all outputs registered; done/err pulses self-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            read_q_reg     <= 1'b0;
            write_q_reg    <= 1'b0;
            addr_out_reg   <= '0;
            data_out_reg   <= '0;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
            read_dn_reg    <= '0;
            write_dn_reg   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_reg        <= '0;
            err_reg        <= '0;
            rw_halt_reg    <= 1'b0;
`endif
        end else begin
            read_dn_reg  <= '0;
            write_dn_reg <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_reg      <= '0;
            rw_halt_reg  <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (pend != 2'b00) begin
                        grant_reg      <= pick;
                        last_grant_reg <= pick;
                        addr_out_reg   <= req_addr[pick];
                        data_out_reg   <= req_wdata[pick];
                        // A master asking for both gets its read first.
                        read_q_reg     <= req_rd[pick];
                        write_q_reg    <= ~req_rd[pick];
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_reg        <= '0;
`endif
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Only a done of the issued type completes; the other is ignored.
                    if (read_q_reg && read_dn) begin
                        rdata_reg[grant_reg]   <= data_in;
                        read_dn_reg[grant_reg] <= 1'b1;
                        read_q_reg             <= 1'b0;
                        state_reg              <= DONE;
                    end else if (write_q_reg && write_dn) begin
                        write_dn_reg[grant_reg] <= 1'b1;
                        write_q_reg             <= 1'b0;
                        state_reg               <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Checked after the done paths so a late done still wins.
                    else if (cnt_reg == CNT_LAST) begin
                        err_reg[grant_reg] <= 1'b1;
                        rw_halt_reg        <= 1'b1;
                        read_q_reg         <= 1'b0;
                        write_q_reg        <= 1'b0;
                        state_reg          <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // Gap cycle lets the served master drop its request.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign read_q      = read_q_reg;
    assign write_q     = write_q_reg;
    assign addr_out    = addr_out_reg;
    assign data_out    = data_out_reg;
    assign m0_rdata    = rdata_reg[0];
    assign m1_rdata    = rdata_reg[1];
    assign m0_read_dn  = read_dn_reg[0];
    assign m1_read_dn  = read_dn_reg[1];
    assign m0_write_dn = write_dn_reg[0];
    assign m1_write_dn = write_dn_reg[1];

`ifdef MEM_ARB_TIMEOUT_EN
    assign m0_err  = err_reg[0];
    assign m1_err  = err_reg[1];
    assign rw_halt = rw_halt_reg;
`else
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
    assign rw_halt = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter. Inputs change 1 ns after each rising
// edge and outputs are sampled at that same point, so every check sees the
// registered result of the edge just taken. Watchdog checks follow
// MEM_ARB_TIMEOUT_EN (DUT built with TIMEOUT_CYCLES = 8).
module tb_mem_req_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_read_q, m0_write_q, m1_read_q, m1_write_q;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_read_dn, m0_write_dn, m0_err;
    logic        m1_read_dn, m1_write_dn, m1_err;
    logic        read_q, write_q, rw_halt;
    logic [31:0] addr_out, data_out, data_in;
    logic        read_dn, write_dn;

    int passed = 0;
    int total  = 0;

    mem_req_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_read_q(m0_read_q), .m0_write_q(m0_write_q), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_read_dn(m0_read_dn),
        .m0_write_dn(m0_write_dn), .m0_err(m0_err),
        .m1_read_q(m1_read_q), .m1_write_q(m1_write_q), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_read_dn(m1_read_dn),
        .m1_write_dn(m1_write_dn), .m1_err(m1_err),
        .read_q(read_q), .write_q(write_q), .addr_out(addr_out),
        .data_out(data_out), .data_in(data_in), .read_dn(read_dn),
        .write_dn(write_dn), .rw_halt(rw_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_read_q = 0; m0_write_q = 0; m0_addr = '0; m0_wdata = '0;
        m1_read_q = 0; m1_write_q = 0; m1_addr = '0; m1_wdata = '0;
        data_in = '0; read_dn = 0; write_dn = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({read_q, write_q, rw_halt} !== 3'b000) $display("FAIL reset_q: got %b expected 000", {read_q, write_q, rw_halt}); else passed++;
        total++; if ({addr_out, data_out} !== 64'h0) $display("FAIL reset_bus: got %h expected 0", {addr_out, data_out}); else passed++;
        total++; if ({m0_rdata, m1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata}); else passed++;
        total++; if ({m0_read_dn, m0_write_dn, m0_err, m1_read_dn, m1_write_dn, m1_err} !== 6'b0)
            $display("FAIL reset_dn: got %b expected 000000", {m0_read_dn, m0_write_dn, m0_err, m1_read_dn, m1_write_dn, m1_err}); else passed++;
    endtask

    task automatic test_single_read();
        m0_read_q = 1; m0_addr = 32'h11;
        total++; if (read_q !== 1'b0) $display("FAIL rd_early: read_q got %b expected 0", read_q); else passed++;
        tick();
        total++; if ({read_q, write_q} !== 2'b10) $display("FAIL rd_issue: q got %b expected 10", {read_q, write_q}); else passed++;
        total++; if (addr_out !== 32'h11) $display("FAIL rd_addr: got %h expected 11", addr_out); else passed++;
        tick();
        total++; if ({read_q, m0_read_dn} !== 2'b10) $display("FAIL rd_hold: q/dn got %b expected 10", {read_q, m0_read_dn}); else passed++;
        data_in = 32'h10; read_dn = 1;
        tick();
        read_dn = 0; m0_read_q = 0;
        $display("txn: m0 read addr=%h data=%h", addr_out, m0_rdata);
        total++; if ({m0_read_dn, read_q} !== 2'b10) $display("FAIL rd_dn: dn/q got %b expected 10", {m0_read_dn, read_q}); else passed++;
        total++; if (m0_rdata !== 32'h10) $display("FAIL rd_data: got %h expected 10", m0_rdata); else passed++;
        total++; if ({m1_read_dn, m1_write_dn, m1_err, m1_rdata} !== 35'h0) $display("FAIL rd_m1_quiet: got %h expected 0", {m1_read_dn, m1_write_dn, m1_err, m1_rdata}); else passed++;
        tick();
        total++; if ({m0_read_dn, m0_rdata} !== {1'b0, 32'h10}) $display("FAIL rd_pulse_end: got %h expected 010", {m0_read_dn, m0_rdata}); else passed++;
        tick();
        total++; if (read_q !== 1'b0) $display("FAIL rd_idle: read_q got %b expected 0", read_q); else passed++;
    endtask

    task automatic test_dual_write();
        do_reset();
        m0_write_q = 1; m0_addr = 32'h05; m0_wdata = 32'hAA;
        m1_write_q = 1; m1_addr = 32'h06; m1_wdata = 32'hBB;
        tick();
        total++; if ({write_q, addr_out, data_out} !== {1'b1, 32'h05, 32'hAA}) $display("FAIL wr_first: got %h expected 1_00000005_000000aa", {write_q, addr_out, data_out}); else passed++;
        write_dn = 1;
        tick();
        write_dn = 0; m0_write_q = 0;
        $display("txn: m0 write addr=05 data=aa");
        total++; if ({m0_write_dn, m1_write_dn, write_q} !== 3'b100) $display("FAIL wr_dn0: got %b expected 100", {m0_write_dn, m1_write_dn, write_q}); else passed++;
        tick();
        total++; if ({m0_write_dn, write_q} !== 2'b00) $display("FAIL wr_gap: got %b expected 00", {m0_write_dn, write_q}); else passed++;
        tick();
        total++; if ({write_q, addr_out, data_out} !== {1'b1, 32'h06, 32'hBB}) $display("FAIL wr_second: got %h expected 1_00000006_000000bb", {write_q, addr_out, data_out}); else passed++;
        write_dn = 1;
        tick();
        write_dn = 0; m1_write_q = 0;
        $display("txn: m1 write addr=06 data=bb");
        total++; if ({m1_write_dn, m0_write_dn} !== 2'b10) $display("FAIL wr_dn1: got %b expected 10", {m1_write_dn, m0_write_dn}); else passed++;
        tick();
        total++; if (m1_write_dn !== 1'b0) $display("FAIL wr_dn1_end: got %b expected 0", m1_write_dn); else passed++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        logic [31:0] own_rd, other_rd;
        logic        own_dn, other_dn;
        m0_read_q = 1; m0_addr = 32'h20;
        m1_read_q = 1; m1_addr = 32'h30;
        for (int i = 0; i < 4; i++) begin
            // last grant before this loop went to m1, so m0 starts
            exp_addr = (i % 2 == 0) ? 32'h20 : 32'h30;
            tick();
            total++; if ({read_q, addr_out} !== {1'b1, exp_addr}) $display("FAIL rr_grant%0d: got %h expected 1_%h", i, {read_q, addr_out}, exp_addr); else passed++;
            data_in = 32'h100 + i; read_dn = 1;
            tick();
            read_dn = 0;
            if (i == 3) begin m0_read_q = 0; m1_read_q = 0; end
            own_dn   = (i % 2 == 0) ? m0_read_dn : m1_read_dn;
            other_dn = (i % 2 == 0) ? m1_read_dn : m0_read_dn;
            own_rd   = (i % 2 == 0) ? m0_rdata : m1_rdata;
            other_rd = (i % 2 == 0) ? m1_rdata : m0_rdata;
            $display("txn: m%0d read addr=%h data=%h", i % 2, exp_addr, own_rd);
            total++; if ({own_dn, other_dn} !== 2'b10) $display("FAIL rr_dn%0d: got %b expected 10", i, {own_dn, other_dn}); else passed++;
            total++; if (own_rd !== 32'h100 + i) $display("FAIL rr_data%0d: got %h expected %h", i, own_rd, 32'h100 + i); else passed++;
            if (i > 0) begin
                total++; if (other_rd !== 32'h100 + i - 1) $display("FAIL rr_hold%0d: got %h expected %h", i, other_rd, 32'h100 + i - 1); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_read_priority();
        m1_read_q = 1; m1_write_q = 1; m1_addr = 32'h44; m1_wdata = 32'hCC;
        tick();
        total++; if ({read_q, write_q, addr_out} !== {2'b10, 32'h44}) $display("FAIL pri_read: got %h expected 2_00000044", {read_q, write_q, addr_out}); else passed++;
        write_dn = 1;
        tick();
        write_dn = 0;
        total++; if ({read_q, m1_read_dn, m1_write_dn} !== 3'b100) $display("FAIL pri_wrong_dn: got %b expected 100", {read_q, m1_read_dn, m1_write_dn}); else passed++;
        data_in = 32'h5A; read_dn = 1;
        tick();
        read_dn = 0; m1_read_q = 0;
        $display("txn: m1 read addr=44 data=%h", m1_rdata);
        total++; if ({m1_read_dn, m1_write_dn, m1_rdata} !== {2'b10, 32'h5A}) $display("FAIL pri_rd_dn: got %h expected 2_0000005a", {m1_read_dn, m1_write_dn, m1_rdata}); else passed++;
        tick();
        tick();
        total++; if ({read_q, write_q, data_out} !== {2'b01, 32'hCC}) $display("FAIL pri_write: got %h expected 1_000000cc", {read_q, write_q, data_out}); else passed++;
        write_dn = 1;
        tick();
        write_dn = 0; m1_write_q = 0;
        $display("txn: m1 write addr=44 data=cc");
        total++; if ({m1_write_dn, m1_read_dn} !== 2'b10) $display("FAIL pri_wr_dn: got %b expected 10", {m1_write_dn, m1_read_dn}); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        m0_read_q = 1; m0_addr = 32'h55;
        tick();
        total++; if (read_q !== 1'b1) $display("FAIL rst_mid_issue: read_q got %b expected 1", read_q); else passed++;
        rst = 1; read_dn = 1; data_in = 32'hEE;
        tick();
        rst = 0; read_dn = 0;
        total++; if ({read_q, m0_read_dn, m0_err, rw_halt, addr_out} !== 36'h0) $display("FAIL rst_mid_abort: got %h expected 0", {read_q, m0_read_dn, m0_err, rw_halt, addr_out}); else passed++;
        total++; if (m0_rdata !== 32'h0) $display("FAIL rst_mid_rdata: got %h expected 0", m0_rdata); else passed++;
        tick();
        total++; if ({read_q, addr_out} !== {1'b1, 32'h55}) $display("FAIL rst_mid_regrant: got %h expected 1_00000055", {read_q, addr_out}); else passed++;
        data_in = 32'h77; read_dn = 1;
        tick();
        read_dn = 0; m0_read_q = 0;
        $display("txn: m0 read addr=55 data=%h", m0_rdata);
        total++; if ({m0_read_dn, m0_rdata} !== {1'b1, 32'h77}) $display("FAIL rst_mid_done: got %h expected 1_00000077", {m0_read_dn, m0_rdata}); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        int early_drop;
        m0_read_q = 1; m0_addr = 32'h66;
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        early_drop = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (read_q !== 1'b1 || m0_err !== 1'b0 || rw_halt !== 1'b0) early_drop++;
        end
        total++; if (early_drop != 0) $display("FAIL to_early: %0d bad cycles, expected 0", early_drop); else passed++;
        tick();
        m0_read_q = 0;
        $display("txn: m0 read addr=66 timed out");
        total++; if ({m0_err, rw_halt, read_q, m1_err, m0_read_dn} !== 5'b11000) $display("FAIL to_fire: got %b expected 11000", {m0_err, rw_halt, read_q, m1_err, m0_read_dn}); else passed++;
        tick();
        total++; if ({m0_err, rw_halt} !== 2'b00) $display("FAIL to_pulse_end: got %b expected 00", {m0_err, rw_halt}); else passed++;
        tick();
        // done arriving in the timeout cycle must win over the watchdog
        m0_read_q = 1;
        tick();
        for (int k = 1; k < 8; k++) tick();
        data_in = 32'h88; read_dn = 1;
        tick();
        read_dn = 0; m0_read_q = 0;
        $display("txn: m0 read addr=66 data=%h", m0_rdata);
        total++; if ({m0_read_dn, m0_err, rw_halt, m0_rdata} !== {3'b100, 32'h88}) $display("FAIL to_dn_wins: got %h expected 4_00000088", {m0_read_dn, m0_err, rw_halt, m0_rdata}); else passed++;
        tick();
`else
        early_drop = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (read_q !== 1'b1 || m0_err !== 1'b0 || rw_halt !== 1'b0) early_drop++;
        end
        total++; if (early_drop != 0) $display("FAIL no_to_hold: %0d bad cycles, expected 0", early_drop); else passed++;
        data_in = 32'h99; read_dn = 1;
        tick();
        read_dn = 0; m0_read_q = 0;
        $display("txn: m0 read addr=66 data=%h", m0_rdata);
        total++; if ({m0_read_dn, m0_err, rw_halt, m0_rdata} !== {3'b100, 32'h99}) $display("FAIL no_to_done: got %h expected 4_00000099", {m0_read_dn, m0_err, rw_halt, m0_rdata}); else passed++;
        tick();
`endif
        tick();
        total++; if ({read_q, write_q} !== 2'b00) $display("FAIL to_idle: got %b expected 00", {read_q, write_q}); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_dual_write();
        test_round_robin();
        test_read_priority();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
